// File: rtl/dma_priority_arbiter_pkg.sv
// Shared DMA types for the request/priority stage in front of the 8237A timing FSM.
package dma_priority_arbiter_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CH_W   = $clog2(NUM_CH);

    // Bit positions of the one-hot arbiter state vector
    typedef enum int unsigned {
        ARB_IDLE_BIT  = 0,
        ARB_HOLD_BIT  = 1,
        ARB_GRANT_BIT = 2
    } ARB_STATE_IDX_e;

    typedef enum logic [2:0] {
        ARB_IDLE  = 3'(1 << ARB_IDLE_BIT),
        ARB_HOLD  = 3'(1 << ARB_HOLD_BIT),
        ARB_GRANT = 3'(1 << ARB_GRANT_BIT)
    } ARB_STATE_e;

    typedef enum logic {
        FIXED_PRI    = 1'b0,
        ROTATING_PRI = 1'b1
    } PRIORITY_MODE_e;

    typedef enum logic [CH_W-1:0] {
        CH0 = 2'd0,
        CH1 = 2'd1,
        CH2 = 2'd2,
        CH3 = 2'd3
    } CHANNEL_SELECT_e;

endpackage

// File: rtl/dma_priority_arbiter_resolver.sv
// Combinational priority resolver: rotate requests so the top-priority channel
// lands at bit 0, find-first-set, then rotate the winning index back.
module dma_priority_resolver
    import dma_priority_arbiter_pkg::*;
(
    input  logic [NUM_CH-1:0] req_i,
    input  PRIORITY_MODE_e    mode_i,
    input  CHANNEL_SELECT_e   last_srv_i,
    output logic [NUM_CH-1:0] grant_c,
    output CHANNEL_SELECT_e   sel_c
);

    logic [CH_W-1:0]   base;
    logic [CH_W-1:0]   idx;
    logic [CH_W-1:0]   first;
    logic [CH_W-1:0]   sel;
    logic [NUM_CH-1:0] rot;

    always_comb begin
        base  = (mode_i == ROTATING_PRI) ? CH_W'(CH_W'(last_srv_i) + CH_W'(1)) : '0;
        rot   = '0;
        idx   = '0;
        first = '0;
        for (int j = 0; j < int'(NUM_CH); j++) begin
            idx    = CH_W'(base + CH_W'(j));
            rot[j] = req_i[idx];
        end
        // Scan downward so the lowest rotated position wins
        for (int j = int'(NUM_CH) - 1; j >= 0; j--) begin
            if (rot[j]) first = CH_W'(j);
        end
        sel     = CH_W'(first + base);
        sel_c   = CHANNEL_SELECT_e'(sel);
        grant_c = (|req_i) ? (NUM_CH'(1) << sel) : '0;
    end

endmodule

// File: rtl/dma_priority_arbiter.sv
// DREQ conditioning, HRQ/HLDA handshake and channel grant for the 8237A timing FSM.
// Define DMA_ARB_SWREQ_EN to add the requestReg software-request port.
module dma_priority_arbiter
    import dma_priority_arbiter_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic              HLDA,
    input  logic [NUM_CH-1:0] maskReg,
`ifdef DMA_ARB_SWREQ_EN
    input  logic [NUM_CH-1:0] requestReg,
`endif
    input  logic              dreqSense,
    input  logic              dackSense,
    input  logic              rotPri,
    input  logic              ctrlDisable,
    input  logic              serviceDone,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    output CHANNEL_SELECT_e   chSel,
    output logic              chValid
);

    ARB_STATE_e        state_q, state_d;
    logic [NUM_CH-1:0] req_q, req_d;
    logic [NUM_CH-1:0] sw_req;
    logic [NUM_CH-1:0] grant_q, grant_d;
    CHANNEL_SELECT_e   ch_sel_q, ch_sel_d;
    CHANNEL_SELECT_e   last_srv_q, last_srv_d;
    logic              hrq_q, hrq_d;
    logic              ch_valid_q, ch_valid_d;
    logic              req_any;
    logic [NUM_CH-1:0] res_grant;
    CHANNEL_SELECT_e   res_sel;
    PRIORITY_MODE_e    pri_mode;

`ifdef DMA_ARB_SWREQ_EN
    assign sw_req = requestReg;
`else
    assign sw_req = '0;
`endif

    // Software requests bypass the mask, as on the 8237A
    assign req_d    = ((DREQ ^ {NUM_CH{dreqSense}}) & ~maskReg) | sw_req;
    assign req_any  = |req_q;
    assign pri_mode = rotPri ? ROTATING_PRI : FIXED_PRI;

    dma_priority_resolver u_resolver (
        .req_i      (req_q),
        .mode_i     (pri_mode),
        .last_srv_i (last_srv_q),
        .grant_c    (res_grant),
        .sel_c      (res_sel)
    );

    always_ff @(posedge CLK) begin
        if (RESET) state_q <= ARB_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:  if (req_any && !ctrlDisable) state_d = ARB_HOLD;
            ARB_HOLD: begin
                if (ctrlDisable || !req_any) state_d = ARB_IDLE;
                else if (HLDA)               state_d = ARB_GRANT;
            end
            ARB_GRANT: if (serviceDone || !HLDA) state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    // Grant is captured on HOLD->GRANT; the pointer moves only on a completed service
    always_comb begin
        hrq_d      = (state_d != ARB_IDLE);
        ch_valid_d = (state_d == ARB_GRANT);
        ch_sel_d   = ch_sel_q;
        grant_d    = grant_q;
        last_srv_d = last_srv_q;
        if (state_q == ARB_HOLD && state_d == ARB_GRANT) begin
            ch_sel_d = res_sel;
            grant_d  = res_grant;
        end
        if (state_q == ARB_GRANT && state_d == ARB_IDLE) begin
            grant_d = '0;
            if (serviceDone) last_srv_d = ch_sel_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            req_q      <= '0;
            hrq_q      <= 1'b0;
            ch_valid_q <= 1'b0;
            ch_sel_q   <= CH0;
            grant_q    <= '0;
            last_srv_q <= CH3;
        end else begin
            req_q      <= req_d;
            hrq_q      <= hrq_d;
            ch_valid_q <= ch_valid_d;
            ch_sel_q   <= ch_sel_d;
            grant_q    <= grant_d;
            last_srv_q <= last_srv_d;
        end
    end

    assign HRQ     = hrq_q;
    assign chValid = ch_valid_q;
    assign chSel   = ch_sel_q;
    assign DACK    = dackSense ? grant_q : ~grant_q;

endmodule
